// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver with mid-bit sampling.
// The line is synchronised through two flops. A start bit is confirmed at
// its mid-point, each data bit is sampled one bit period later (LSB first),
// and the stop bit decides between a valid strobe and a frame error.
// All outputs come straight from registers.
module uart_rx #(
    parameter int p_DATA_WIDTH = 8,
    parameter int p_PERIOD     = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_rx,
    output logic [p_DATA_WIDTH-1:0] ov_data,
    output logic                    o_valid,
    output logic                    o_frame_err,
    output logic                    o_busy
);

    localparam int CW = (p_PERIOD > 1) ? $clog2(p_PERIOD) : 1;
    localparam int IW = (p_DATA_WIDTH > 0) ? $clog2(p_DATA_WIDTH + 1) : 1;

    // Compare values for the bit-time counter and the bit index.
    localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(32'd0);
    localparam logic [CW-1:0] HALF_LAST = CW'((p_PERIOD / 2) - 1);
    localparam logic [CW-1:0] PER_LAST  = CW'(p_PERIOD - 1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(32'd1);
    localparam logic [IW-1:0] IDX_ZERO  = IW'(32'd0);
    localparam logic [IW-1:0] IDX_LAST  = IW'(p_DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    // Registered state
    state_t                  state_r;
    logic                    rx_meta_r;
    logic                    rx_sync_r;     // synchronised line used by every decision
    logic [CW-1:0]           cnt_r;
    logic [IW-1:0]           idx_r;
    logic [p_DATA_WIDTH-1:0] shift_r;
    logic [p_DATA_WIDTH-1:0] data_r;
    logic                    valid_r;
    logic                    ferr_r;
    logic                    busy_r;

    // Next-state values
    state_t                  state_s;
    logic [CW-1:0]           cnt_s;
    logic [IW-1:0]           idx_s;
    logic [p_DATA_WIDTH-1:0] shift_s;
    logic [p_DATA_WIDTH-1:0] data_s;
    logic                    valid_s;
    logic                    ferr_s;
    logic                    busy_s;
    logic [p_DATA_WIDTH:0]   shift_ext_s;

    // New bit enters at the MSB; dropping bit 0 of the extended vector is a
    // right shift that also works for a one-bit word.
    assign shift_ext_s = {rx_sync_r, shift_r};

    // Two-flop synchroniser for the asynchronous serial line; resets to idle-high.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= i_rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // State register plus datapath and output registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            idx_r   <= IDX_ZERO;
            shift_r <= {p_DATA_WIDTH{1'b0}};
            data_r  <= {p_DATA_WIDTH{1'b0}};
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            ferr_r  <= ferr_s;
            busy_r  <= busy_s;
        end
    end

    // Next-state, counter and strobe logic for the frame receiver.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        shift_s = shift_r;
        data_s  = data_r;
        valid_s = 1'b0;
        ferr_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                cnt_s = CNT_ZERO;
                if (!rx_sync_r) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_s = CNT_ZERO;
                    if (rx_sync_r) begin
                        // Low pulse shorter than half a bit: treat as noise.
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DATA;
                        idx_s   = IDX_ZERO;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            ST_DATA: begin
                if (cnt_r == PER_LAST) begin
                    cnt_s   = CNT_ZERO;
                    shift_s = shift_ext_s[p_DATA_WIDTH:1];
                    if (idx_r == IDX_LAST) begin
                        state_s = ST_STOP;
                    end else begin
                        idx_s = idx_r + IDX_ONE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            ST_STOP: begin
                if (cnt_r == PER_LAST) begin
                    cnt_s = CNT_ZERO;
                    if (rx_sync_r) begin
                        data_s  = shift_r;
                        valid_s = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        // Bad stop bit: report once, then wait out any break.
                        ferr_s  = 1'b1;
                        state_s = ST_BREAK;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            ST_BREAK: begin
                cnt_s = CNT_ZERO;
                if (rx_sync_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BREAK;
                end
            end

            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    assign ov_data     = data_r;
    assign o_valid     = valid_r;
    assign o_frame_err = ferr_r;
    assign o_busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. Instance A uses 8 data bits at
// 4 clocks/bit; instance B uses 4 data bits at 2 clocks/bit and is fed by a
// behavioural transmitter for the loopback sequence.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [7:0] ov_data_a;
    logic       valid_a, ferr_a, busy_a;
    logic [3:0] ov_data_b;
    logic       valid_b, ferr_b, busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor bookkeeping
    int cyc = 0;
    int qa_data[$];
    int qa_time[$];
    int qb_data[$];
    int ferr_cnt_a = 0;
    int ferr_cnt_b = 0;
    int busy_cnt_a = 0;
    int overlap_a  = 0;
    int overlap_b  = 0;

    uart_rx #(.p_DATA_WIDTH(8), .p_PERIOD(4)) u_dut_a (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_rx        (rx_a),
        .ov_data     (ov_data_a),
        .o_valid     (valid_a),
        .o_frame_err (ferr_a),
        .o_busy      (busy_a)
    );

    uart_rx #(.p_DATA_WIDTH(4), .p_PERIOD(2)) u_dut_b (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_rx        (rx_b),
        .ov_data     (ov_data_b),
        .o_valid     (valid_b),
        .o_frame_err (ferr_b),
        .o_busy      (busy_b)
    );

    // Clock generation
    always #5 clk = ~clk;

    // Rising-edge counter used to time strobes
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (valid_a === 1'b1) begin
            qa_data.push_back(int'(ov_data_a));
            qa_time.push_back(cyc);
        end
        if (ferr_a === 1'b1) ferr_cnt_a <= ferr_cnt_a + 1;
        if (busy_a === 1'b1) busy_cnt_a <= busy_cnt_a + 1;
        if (valid_a === 1'b1 && ferr_a === 1'b1) overlap_a <= overlap_a + 1;
        if (valid_b === 1'b1) qb_data.push_back(int'(ov_data_b));
        if (ferr_b === 1'b1) ferr_cnt_b <= ferr_cnt_b + 1;
        if (valid_b === 1'b1 && ferr_b === 1'b1) overlap_b <= overlap_b + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Hold a line level for n clocks; levels change 1 time unit after a rising edge.
    task automatic drive(input int which, input logic v, input int n);
        if (which == 0) rx_a = v;
        else            rx_b = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int which, input logic [7:0] data, input int nbits,
                              input int per, input logic stop);
        drive(which, 1'b0, per);
        for (int i = 0; i < nbits; i++) drive(which, data[i], per);
        drive(which, stop, per);
    endtask

    int t0, na, nb, nf, bc;
    logic [7:0] byte_v;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_data_a",  {24'd0, ov_data_a}, 32'h0);
        check_eq("rst_valid_a", {31'd0, valid_a},   32'h0);
        check_eq("rst_ferr_a",  {31'd0, ferr_a},    32'h0);
        check_eq("rst_busy_a",  {31'd0, busy_a},    32'h0);
        check_eq("rst_data_b",  {28'd0, ov_data_b}, 32'h0);
        i_reset = 1'b1;
        drive(0, 1'b1, 5);

        // Good frame 0xA5 with latency check: 2 (sync) + H + 9*P + 1 = 41
        na = qa_data.size();
        nf = ferr_cnt_a;
        t0 = cyc;
        send_frame(0, 8'hA5, 8, 4, 1'b1);
        drive(0, 1'b1, 10);
        check_eq("good_count", qa_data.size() - na, 32'd1);
        if (qa_data.size() > na) begin
            check_eq("good_data",    qa_data[na],      32'hA5);
            check_eq("good_latency", qa_time[na] - t0, 32'd41);
        end
        check_eq("good_ov_data", {24'd0, ov_data_a}, 32'hA5);
        check_eq("good_no_ferr", ferr_cnt_a - nf,    32'd0);
        check_eq("good_busy_lo", {31'd0, busy_a},    32'h0);

        // Start glitch: one clock low
        na = qa_data.size();
        nf = ferr_cnt_a;
        bc = busy_cnt_a;
        drive(0, 1'b0, 1);
        drive(0, 1'b1, 12);
        check_eq("glitch_no_valid", qa_data.size() - na, 32'd0);
        check_eq("glitch_no_ferr",  ferr_cnt_a - nf,     32'd0);
        check_eq("glitch_busy_len", {31'd0, (busy_cnt_a - bc >= 1) && (busy_cnt_a - bc <= 3)}, 32'd1);
        check_eq("glitch_busy_lo",  {31'd0, busy_a},     32'h0);
        check_eq("glitch_ov_data",  {24'd0, ov_data_a},  32'hA5);

        // Frame error: 0x3C, stop low, line held low for 40 more clocks
        na = qa_data.size();
        nf = ferr_cnt_a;
        byte_v = 8'h3C;
        drive(0, 1'b0, 4);
        for (int i = 0; i < 8; i++) drive(0, byte_v[i], 4);
        drive(0, 1'b0, 4 + 40);
        check_eq("ferr_busy_hold", {31'd0, busy_a},     32'h1);
        check_eq("ferr_once_hold", ferr_cnt_a - nf,     32'd1);
        drive(0, 1'b1, 8);
        check_eq("ferr_count",     ferr_cnt_a - nf,     32'd1);
        check_eq("ferr_no_valid",  qa_data.size() - na, 32'd0);
        check_eq("ferr_ov_data",   {24'd0, ov_data_a},  32'hA5);
        check_eq("ferr_busy_lo",   {31'd0, busy_a},     32'h0);

        // Back-to-back 0x00 then 0xFF, no idle gap
        na = qa_data.size();
        send_frame(0, 8'h00, 8, 4, 1'b1);
        send_frame(0, 8'hFF, 8, 4, 1'b1);
        drive(0, 1'b1, 10);
        check_eq("b2b_count", qa_data.size() - na, 32'd2);
        if (qa_data.size() >= na + 2) begin
            check_eq("b2b_first",   qa_data[na],                       32'h00);
            check_eq("b2b_second",  qa_data[na+1],                     32'hFF);
            check_eq("b2b_spacing", qa_time[na+1] - qa_time[na],       32'd40);
        end
        check_eq("b2b_ov_data", {24'd0, ov_data_a}, 32'hFF);

        // Reset during data bit 3 of 0x5A
        na = qa_data.size();
        nf = ferr_cnt_a;
        byte_v = 8'h5A;
        drive(0, 1'b0, 4);
        for (int i = 0; i < 3; i++) drive(0, byte_v[i], 4);
        drive(0, byte_v[3], 2);
        i_reset = 1'b0;
        rx_a = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mrst_data",  {24'd0, ov_data_a}, 32'h0);
        check_eq("mrst_valid", {31'd0, valid_a},   32'h0);
        check_eq("mrst_ferr",  {31'd0, ferr_a},    32'h0);
        check_eq("mrst_busy",  {31'd0, busy_a},    32'h0);
        i_reset = 1'b1;
        drive(0, 1'b1, 10);
        check_eq("mrst_no_valid", qa_data.size() - na, 32'd0);
        check_eq("mrst_no_ferr",  ferr_cnt_a - nf,     32'd0);
        send_frame(0, 8'h81, 8, 4, 1'b1);
        drive(0, 1'b1, 10);
        check_eq("mrst_next_count", qa_data.size() - na, 32'd1);
        check_eq("mrst_next_data",  {24'd0, ov_data_a},  32'h81);

        // Loopback on instance B: 4'b0011 then 0..15 back-to-back
        nb = qb_data.size();
        nf = ferr_cnt_b;
        send_frame(1, 8'h03, 4, 2, 1'b1);
        for (int v = 0; v < 16; v++) send_frame(1, 8'(v), 4, 2, 1'b1);
        drive(1, 1'b1, 10);
        check_eq("lb_count", qb_data.size() - nb, 32'd17);
        if (qb_data.size() >= nb + 17) begin
            check_eq("lb_first", qb_data[nb], 32'h3);
            for (int v = 0; v < 16; v++) begin
                check_eq($sformatf("lb_word%0d", v), qb_data[nb+1+v], 32'(v));
            end
        end
        check_eq("lb_no_ferr", ferr_cnt_b - nf,     32'd0);
        check_eq("lb_busy_lo", {31'd0, busy_b},     32'h0);

        // Strobes never coincide
        check_eq("overlap_a", overlap_a, 32'd0);
        check_eq("overlap_b", overlap_b, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver; the downstream partner of UartTx.
- Deserialises an idle-high line into parallel words of p_DATA_WIDTH bits. Frame format: start bit (0), data bits LSB first, one stop bit (1).
- Samples each bit at its mid-point, using the same bit period in clocks (p_PERIOD) as the transmitter.
- Reports each word with a one-cycle valid strobe and flags bad stop bits.

Parameters:
- p_DATA_WIDTH, 8, data bits per frame (>=1).
- p_PERIOD, 16, clocks per bit (>=2); must match the transmitter's p_PERIOD.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_reset  input  1  synchronous, active-low reset (0 = reset).
- i_rx  input  1  serial line, asynchronous to i_clk, idle high.
- ov_data  output  p_DATA_WIDTH  last correctly framed word; held until the next good frame.
- o_valid  output  1  one-cycle pulse: ov_data has just been updated.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low; frame discarded.
- o_busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (i_reset==0 at a rising edge):
  - state=IDLE; counters=0; 2-flop synchroniser=1,1.
  - ov_data=0, o_valid=0, o_frame_err=0, o_busy=0.
  - Reset wins over any frame in progress; the partial word is dropped and no strobes are issued.
- Synchroniser: i_rx passes through 2 flops; rx_s is i_rx delayed 2 clocks. All decisions use rx_s only.
- Counters:
  - Bit-time counter: width clog2(p_PERIOD).
  - Bit index: width clog2(p_DATA_WIDTH+1).
  - Shift register: p_DATA_WIDTH bits, filled LSB first (right shift, new bit into MSB).
- Timing: let T be the edge at which IDLE sees rx_s==0. Let H = floor(p_PERIOD/2).
- States:
  - IDLE:
    - rx_s==0 -> START, bit-time counter cleared.
  - START:
    - At edge T+H, sample rx_s.
    - 1 -> glitch, back to IDLE; no strobe.
    - 0 -> DATA, bit index=0.
  - DATA:
    - Data bit k (0..p_DATA_WIDTH-1) is sampled at T+H+(k+1)*p_PERIOD.
    - After the last bit -> STOP.
  - STOP:
    - Sample at T+H+(p_DATA_WIDTH+1)*p_PERIOD.
    - rx_s==1 -> ov_data<=shift register, o_valid=1 for the following cycle, state -> IDLE.
    - rx_s==0 -> o_frame_err=1 for the following cycle, ov_data unchanged, state -> BREAK.
  - BREAK:
    - Wait until rx_s==1, then -> IDLE.
    - A line held low (break condition) produces exactly one o_frame_err, not repeated ones.
- Back-to-back frames: after a good stop sample, IDLE can detect the next start on the very next edge. Zero idle bits between frames must be received correctly.
- o_valid and o_frame_err are never high together, and each is high for exactly one cycle per frame.
- o_busy rises on the edge after T. It falls when IDLE is re-entered, and stays high through BREAK.
- Latency: the o_valid cycle begins H+(p_DATA_WIDTH+1)*p_PERIOD+1 clocks after the falling start edge reaches rx_s, which is 2 clocks after it reaches i_rx.

Test Plan:
- Good frame (p_DATA_WIDTH=8, p_PERIOD=4): send 0xA5, idle high before and after -> exactly one o_valid pulse, ov_data=0xA5, o_frame_err never high, o_busy low afterwards.
- Start glitch: drive i_rx low for 1 clock, then high (p_PERIOD=4) -> no o_valid, no o_frame_err, o_busy high for at most H+1 cycles and then 0, ov_data unchanged.
- Frame error:
  - Send 0x3C with the stop bit forced low, then hold the line low for 40 clocks, then release.
  - Required: exactly one o_frame_err pulse, ov_data still 0xA5 from the previous frame, o_busy high until rx_s returns to 1.
- Back-to-back: send 0x00 then 0xFF with no idle gap -> two o_valid pulses exactly 10*p_PERIOD clocks apart, ov_data=0x00 then 0xFF.
- Reset mid-frame: assert i_reset=0 for 1 clock during data bit 3 -> all outputs 0, no strobes. The next clean frame 0x81 is received correctly.
- Loopback with UartTx (p_DATA_WIDTH=4, p_PERIOD=2): transmit 4'b0011, then all 16 values in sequence -> each received value equals the sent value with one o_valid per word, and no frame errors.
